// File: rtl/vic_pkg.sv
// rtl/vic_pkg.sv - shared types and constants for the VIC interrupt responder
package vic_pkg;

  localparam int ID_W = 5;
  localparam logic [31:0] VIC_DEF_VEC = 32'h0000_0100;

  typedef logic [ID_W-1:0] vic_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LOAD  = 2'd3
  } vic_state_e;

  // Each vector table entry is one 32-bit word; the sum wraps at 32 bits.
  function automatic logic [31:0] vt_entry_addr(input logic [31:0] base, input vic_id_t id);
    return base + {25'd0, id, 2'b00};
  endfunction

endpackage

// File: rtl/vic_id_stack.sv
// rtl/vic_id_stack.sv - LIFO of in-service interrupt ids; pop applies before push
module vic_id_stack
  import vic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  vic_id_t    i_push_id,
  input  logic       i_pop,
  output vic_id_t    o_top,
  output logic [2:0] o_depth
);

  vic_id_t    mem_q [DEPTH];
  vic_id_t    mem_d [DEPTH];
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] after_pop;

  // A pop on an empty stack is a no-op; a push to a full stack is dropped.
  always_comb begin
    mem_d     = mem_q;
    after_pop = cnt_q;
    if (i_pop && cnt_q != 3'd0) begin
      after_pop = cnt_q - 3'd1;
    end
    cnt_d = after_pop;
    if (i_push && int'(after_pop) < DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(after_pop) == i) begin
          mem_d[i] = i_push_id;
        end
      end
      cnt_d = after_pop + 3'd1;
    end
  end

  always_comb begin
    o_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(cnt_q) == i + 1) begin
        o_top = mem_q[i];
      end
    end
  end

  assign o_depth = cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/vic_irq_resp.sv
// rtl/vic_irq_resp.sv - CPU-side interrupt responder: vector fetch, PC load, nesting stack
module vic_irq_resp
  import vic_pkg::*;
#(
  parameter logic [31:0] VT_BASE    = 32'h0000_0000,
  parameter int          DEPTH      = 4,
  parameter int          VT_TIMEOUT = 15,
  parameter logic [31:0] DEF_VEC    = VIC_DEF_VEC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_irq,
  input  logic [4:0]  i_irq_addr,
  input  logic        i_gie,
  input  logic        i_cpu_ready,
  input  logic        i_reti,
  input  logic [31:0] i_vt_data,
  input  logic        i_vt_valid,
  output logic        o_ack,
  output logic        o_vt_rd,
  output logic [31:0] o_vt_addr,
  output logic        o_pc_load,
  output logic [31:0] o_pc_value,
  output logic        o_active,
  output logic [4:0]  o_cur_id,
  output logic [2:0]  o_depth,
  output logic        o_err
);

  localparam int TW = $clog2(VT_TIMEOUT + 1);

  vic_state_e    state_q, state_d;
  vic_id_t       pend_id_q, pend_id_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   vt_addr_q, vt_addr_d;
  logic [31:0]   pc_value_q, pc_value_d;
  logic          vt_rd_q, vt_rd_d;
  logic          pc_load_q, pc_load_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  vic_id_t       top_id;
  logic [2:0]    depth;
  logic          push;
  logic          accept;

  vic_id_stack #(.DEPTH(DEPTH)) u_stack (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (push),
    .i_push_id (pend_id_q),
    .i_pop     (i_reti),
    .o_top     (top_id),
    .o_depth   (depth)
  );

  assign push   = (state_q == ST_LOAD);
  assign accept = i_irq && i_gie && i_cpu_ready && (int'(depth) < DEPTH) &&
                  (depth == 3'd0 || i_irq_addr < top_id);

  always_comb begin
    state_d    = state_q;
    pend_id_d  = pend_id_q;
    wait_cnt_d = wait_cnt_q;
    vt_addr_d  = vt_addr_q;
    pc_value_d = pc_value_q;
    err_d      = err_q;
    vt_rd_d    = 1'b0;
    pc_load_d  = 1'b0;
    ack_d      = 1'b0;

    if (i_reti && depth == 3'd0) begin
      err_d = 1'b1;
    end

    // Strobes are computed one state early so they are flop outputs in FETCH/LOAD.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_FETCH;
          pend_id_d = i_irq_addr;
          vt_addr_d = vt_entry_addr(VT_BASE, i_irq_addr);
          vt_rd_d   = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (i_vt_valid) begin
          pc_value_d = i_vt_data;
          pc_load_d  = 1'b1;
          ack_d      = 1'b1;
          state_d    = ST_LOAD;
        end else if (wait_cnt_q == TW'(VT_TIMEOUT - 1)) begin
          pc_value_d = DEF_VEC;
          err_d      = 1'b1;
          pc_load_d  = 1'b1;
          ack_d      = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pend_id_q  <= '0;
      wait_cnt_q <= '0;
      vt_addr_q  <= '0;
      pc_value_q <= '0;
      vt_rd_q    <= 1'b0;
      pc_load_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_id_q  <= pend_id_d;
      wait_cnt_q <= wait_cnt_d;
      vt_addr_q  <= vt_addr_d;
      pc_value_q <= pc_value_d;
      vt_rd_q    <= vt_rd_d;
      pc_load_q  <= pc_load_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_vt_rd    = vt_rd_q;
  assign o_vt_addr  = vt_addr_q;
  assign o_pc_load  = pc_load_q;
  assign o_pc_value = pc_value_q;
  assign o_err      = err_q;
  assign o_active   = (depth != 3'd0);
  assign o_cur_id   = top_id;
  assign o_depth    = depth;

endmodule

// File: doc/vic_irq_resp.md
VIC_IRQ_RESP -- requirements
Module: vic_irq_resp

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- VT_BASE, 32'h0000_0000, vector table byte base address
- DEPTH, 4, maximum nesting depth
- VT_TIMEOUT, 15, maximum wait cycles for vector data
- DEF_VEC, 32'h0000_0100, fallback handler address
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- i_clk, in, 1, single clock, rising edge
- i_rst_n, in, 1, reset, asynchronous, active-low
- i_irq, in, 1, interrupt request from VIC (its o_IRQ)
- i_irq_addr, in, 5, requesting source index from VIC (its o_irq_addr)
- i_gie, in, 1, global interrupt enable
- i_cpu_ready, in, 1, CPU at instruction boundary
- i_reti, in, 1, return-from-interrupt pulse
- i_vt_data, in, 32, vector table read data
- i_vt_valid, in, 1, vector table read data valid
- o_ack, out, 1, acknowledge to VIC (its i_IRQ)
- o_vt_rd, out, 1, vector table read strobe
- o_vt_addr, out, 32, vector table read address
- o_pc_load, out, 1, PC load strobe
- o_pc_value, out, 32, handler address
- o_active, out, 1, at least one handler in service
- o_cur_id, out, 5, source in service (top of stack)
- o_depth, out, 3, current nesting depth
- o_err, out, 1, sticky error flag

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, FETCH, WAIT, LOAD.
REQ-004 IDLE->FETCH SHALL occur when all of these hold: i_irq=1; i_gie=1; i_cpu_ready=1; depth<DEPTH; and either depth=0 or i_irq_addr<o_cur_id.
REQ-005 On the IDLE->FETCH transition, i_irq_addr SHALL be latched as the pending id, and lower index SHALL mean higher priority.
REQ-006 In FETCH, o_vt_rd SHALL be 1 for exactly one cycle and o_vt_addr SHALL be VT_BASE + {pending id, 2'b00} (32-bit wrap); the next state SHALL be WAIT.
REQ-007 In WAIT, i_vt_valid=1 SHALL capture i_vt_data and move to LOAD; i_vt_valid outside WAIT SHALL be ignored.
REQ-008 If WAIT persists VT_TIMEOUT cycles without valid, the block SHALL use DEF_VEC, set o_err, and move to LOAD.
REQ-009 LOAD SHALL last one cycle, with o_pc_load=1, o_ack=1 and o_pc_value set to the captured address; the pending id SHALL be pushed and the next state SHALL be IDLE.
REQ-010 Minimum latency SHALL be: accept in cycle T, o_vt_rd in T+1, i_vt_valid in T+2, o_pc_load/o_ack in T+3.
REQ-011 o_pc_value SHALL hold its last loaded value between loads.
REQ-012 i_reti=1 SHALL pop the stack in any state; i_reti with depth=0 SHALL set o_err and change nothing else.
REQ-013 i_reti coincident with LOAD SHALL pop first, then push, so the new id replaces the top and depth is unchanged.
REQ-014 i_irq falling during FETCH/WAIT SHALL NOT abort the sequence; the latched id SHALL be serviced.
REQ-015 A request with depth=DEPTH, or with an id not strictly below o_cur_id, SHALL remain in IDLE with no ack.
REQ-016 Outputs SHALL be: o_active = (depth!=0); o_cur_id = top entry, or 5'd0 when empty; o_depth = depth.
REQ-017 o_ack, o_vt_rd and o_pc_load SHALL be registered single-cycle pulses.

Reset
REQ-018 i_rst_n=0 SHALL asynchronously force: state IDLE, stack empty, all outputs 0, o_vt_addr 0, o_pc_value 0, o_err 0.
REQ-019 Reset asserted mid-sequence SHALL discard the pending id, and no ack SHALL follow deassertion.
REQ-020 o_err SHALL clear only by reset.

Structure
REQ-021 State encoding, the 5-bit id width and DEF_VEC SHALL reside in shared package vic_pkg.
REQ-022 The id stack SHALL be sub-module vic_id_stack (push, pop, top, depth, simultaneous pop+push).

Verification
REQ-023 Reset, then i_irq=1, addr=5'd7, gie=1, ready=1, vt_data=32'h0000_2000 valid one cycle after rd -> o_vt_addr=32'h1C, o_pc_load with 32'h2000 at T+3, o_cur_id=7, o_depth=1.
REQ-024 With id 7 active, request id 3 -> preempt, depth=2, cur_id=3; then request id 9 -> no ack.
REQ-025 Hold i_vt_valid=0 -> after 15 WAIT cycles o_pc_value=32'h100, o_err=1.
REQ-026 Two i_reti pulses from depth 2 -> depth 0, o_active=0; a third i_reti -> o_err=1.
REQ-027 Drive i_rst_n=0 during WAIT -> all outputs 0 immediately, no o_ack afterwards.
REQ-028 Fill to DEPTH=4 with ids 20,15,10,5; request id 1 -> no ack, depth stays 4.
